// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared pipeline definitions for the execute-stage multiply/divide unit:
//   - MD_OP encodings driven by decode alongside START
//   - default busy-cycle counts, shared by the stall unit and mult_div
//   - mult_div FSM state encodings
// -----------------------------------------------------------------------------
package mult_div_pkg;

    // MD_OP encodings; 6 and 7 are reserved and behave as no-ops.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Busy-cycle defaults. DIV_CYCLES_DEFAULT must be at least 1.
    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

    // mult_div FSM states.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div
// Execute-stage multiply/divide unit. Holds the HI/LO architectural registers.
// The arithmetic is done behaviourally on the START cycle. The result is parked
// in PEND_HI/PEND_LO, and a down-counter models the multi-cycle latency before
// it is committed to HI/LO. MTHI/MTLO write HI/LO directly with zero latency.
//
// Ports
//   CLK      in   1   clock, rising edge
//   RESET_N  in   1   asynchronous active-low reset
//   START    in   1   one-cycle launch strobe from E
//   MD_OP    in   3   operation (see mult_div_pkg encodings)
//   SRC_A    in  32   rs value (forwarded)
//   SRC_B    in  32   rt value (forwarded)
//   BUSY     out  1   registered; high while a MULT/DIV is in flight
//   HI       out 32   HI register
//   LO       out 32   LO register
//
// Handshake: START is a strobe with no ready. It is accepted only while the unit
// is IDLE. START seen while BUSY, including on the edge where BUSY falls, is
// dropped, so the stall unit must hold dependent ops until BUSY is low.
// -----------------------------------------------------------------------------
module mult_div
    import mult_div_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [2:0]  MD_OP,
    input  logic [31:0] SRC_A,
    input  logic [31:0] SRC_B,
    output logic        BUSY,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    // ---------------------------------------------------------------------
    // Arithmetic, evaluated on the operands presented with START.
    // ---------------------------------------------------------------------
    logic [63:0]        prod_s, prod_u;
    logic               div_zero, div_ovf;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    // Sign-extending both operands to 64 bits makes the low 64 bits of the
    // product the correct two's-complement signed product.
    assign prod_s = {{32{SRC_A[31]}}, SRC_A} * {{32{SRC_B[31]}}, SRC_B};
    assign prod_u = {32'd0, SRC_A} * {32'd0, SRC_B};

    // A zero divisor keeps HI/LO, so the divider result is never used then.
    // -2^31 / -1 overflows; dividing by 1 instead gives the wrapped quotient
    // 0x80000000 with remainder 0. Both substitutions also keep the divider
    // away from an undefined or trapping case.
    assign div_zero = (SRC_B == 32'd0);
    assign div_ovf  = (SRC_A == 32'h8000_0000) && (SRC_B == 32'hFFFF_FFFF);
    assign divisor  = (div_zero || div_ovf) ? 32'd1 : SRC_B;

    // SV signed division truncates toward zero, and the remainder takes the
    // sign of the dividend.
    assign quot_s = $signed(SRC_A) / $signed(divisor);
    assign rem_s  = $signed(SRC_A) % $signed(divisor);
    assign quot_u = SRC_A / divisor;
    assign rem_u  = SRC_A % divisor;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    case (MD_OP)
                        MD_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_DIV: begin
                            pend_hi_d = div_zero ? hi_q : $unsigned(rem_s);
                            pend_lo_d = div_zero ? lo_q : $unsigned(quot_s);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_DIVU: begin
                            pend_hi_d = div_zero ? hi_q : rem_u;
                            pend_lo_d = div_zero ? lo_q : quot_u;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_MTHI: hi_d = SRC_A;
                        MD_MTLO: lo_d = SRC_A;
                        default: ; // reserved: no-op
                    endcase
                end
            end

            ST_RUN: begin
                // START is ignored here. The last busy cycle commits the result.
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
